fifo_word_packer: RTL and testbench

//   Read-side consumer of the 8x8 byte FIFO. Pops bytes via rd/empty, absorbs
//   the FIFO's one-cycle registered data_out latency, packs BYTES_PER_WORD bytes

---
 rtl/fifo_word_packer.sv | 130 +++++++++++++
 tb/tb_fifo_word_packer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// Read-side FIFO consumer: pops bytes, absorbs the FIFO's registered-read latency and packs
// BYTES_PER_WORD bytes per valid/ready word. Optional partial-word flush: FIFO_WORD_PACKER_FLUSH_EN.
module fifo_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int FLUSH_TIMEOUT  = 16
) (
  input  logic                        rd_clk,
  input  logic                        reset,
  input  logic                        fifo_empty,
  input  logic [7:0]                  fifo_data,
  output logic                        fifo_rd,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic [BYTES_PER_WORD-1:0]   word_be,
  output logic                        word_valid,
  input  logic                        word_ready
);

  localparam int BPW = BYTES_PER_WORD;
  localparam int CW  = $clog2(BPW + 1);

  if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8 || FLUSH_TIMEOUT < 2) begin : g_bad_param
    $error("fifo_word_packer: illegal parameter value");
  end

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  pend, pop;
  logic [8*BPW-1:0]      stage, stage_nxt;
  logic [8*BPW-1:0]      word_out_nxt;
  logic [BPW-1:0]        word_be_nxt;
  logic                  word_valid_nxt;

`ifdef FIFO_WORD_PACKER_FLUSH_EN
  localparam int IW = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  logic [IW-1:0]         idle, idle_nxt;
`endif

  // pend counts a popped byte whose data arrives next cycle, so it must not be over-popped
  always_comb begin
    fifo_rd = (state == FILL) && !fifo_empty && !reset &&
              (({1'b0, cnt} + {{CW{1'b0}}, pend}) < (CW + 1)'(BPW));
  end

  assign pop = fifo_rd && !fifo_empty;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    stage_nxt      = stage;
    word_out_nxt   = word_out;
    word_be_nxt    = word_be;
    word_valid_nxt = word_valid;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    idle_nxt       = idle;
`endif
    case (state)
      FILL: begin
        if (pend) begin
          for (int i = 0; i < BPW; i++) begin
            if (cnt == CW'(i)) stage_nxt[8*i +: 8] = fifo_data;
          end
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(BPW - 1)) begin
            word_out_nxt   = stage_nxt;
            word_be_nxt    = '1;
            word_valid_nxt = 1'b1;
            stage_nxt      = '0;
            cnt_nxt        = '0;
            state_nxt      = HOLD;
          end
        end
`ifdef FIFO_WORD_PACKER_FLUSH_EN
        // Idle only accrues while a partial word is parked with nothing in flight
        if (pop || pend) begin
          idle_nxt = '0;
        end else if (cnt != '0) begin
          if (idle == IW'(FLUSH_TIMEOUT - 1)) begin
            word_out_nxt   = stage;
            for (int i = 0; i < BPW; i++) word_be_nxt[i] = (CW'(i) < cnt);
            word_valid_nxt = 1'b1;
            stage_nxt      = '0;
            cnt_nxt        = '0;
            idle_nxt       = '0;
            state_nxt      = HOLD;
          end else begin
            idle_nxt = idle + IW'(1);
          end
        end
`endif
      end
      HOLD: begin
        if (word_ready) begin
          word_valid_nxt = 1'b0;
          word_be_nxt    = '0;
          state_nxt      = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state      <= FILL;
      cnt        <= '0;
      pend       <= 1'b0;
      stage      <= '0;
      word_out   <= '0;
      word_be    <= '0;
      word_valid <= 1'b0;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
      idle       <= '0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend       <= pop;
      stage      <= stage_nxt;
      word_out   <= word_out_nxt;
      word_be    <= word_be_nxt;
      word_valid <= word_valid_nxt;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
      idle       <= idle_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: models the upstream FIFO and scores every accepted word
// against the pushed byte stream taken BPW bytes at a time.
module tb_fifo_word_packer;

  localparam int BPW = 4;
  localparam int TO  = 16;

  logic                 rd_clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 fifo_empty = 1'b1;
  logic [7:0]           fifo_data = 8'h00;
  logic                 fifo_rd;
  logic [8*BPW-1:0]     word_out;
  logic [BPW-1:0]       word_be;
  logic                 word_valid;
  logic                 word_ready = 1'b0;

  int n_cmp = 0, n_err = 0;
  int pops = 0, emitted = 0, edge_n = 0;
  int first_pop_edge = -1, last_pop_edge = -1;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [8*BPW-1:0] prev_w = '0;
  logic prev_hold = 1'b0;

  always #5 rd_clk = ~rd_clk;

  fifo_word_packer #(.BYTES_PER_WORD(BPW), .FLUSH_TIMEOUT(TO)) dut (
    .rd_clk(rd_clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .word_out(word_out), .word_be(word_be),
    .word_valid(word_valid), .word_ready(word_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // A word carries the oldest outstanding pushed bytes; only a flushed word may be short
  task automatic accept(input logic [8*BPW-1:0] w, input logic [BPW-1:0] be);
    logic [8*BPW-1:0] e = '0;
    logic [BPW-1:0] e_be;
    int n = BPW;
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    if (exp_q.size() < BPW) n = exp_q.size();
`else
    if (exp_q.size() < BPW) chk("word_underflow", 64'(exp_q.size()), 64'(BPW));
`endif
    for (int i = 0; i < n && exp_q.size() > 0; i++) e[8*i +: 8] = exp_q.pop_front();
    e_be = BPW'((1 << n) - 1);
    chk("word", 64'(w), 64'(e));
    chk("word_be", 64'(be), 64'(e_be));
    emitted += n;
  endtask

  task automatic tick();
    logic rd_s, emp_s, v_s, r_s;
    logic [8*BPW-1:0] w_s;
    logic [BPW-1:0] be_s;
    @(negedge rd_clk);
    rd_s = fifo_rd; emp_s = fifo_empty; v_s = word_valid; r_s = word_ready;
    w_s = word_out; be_s = word_be;
    if (v_s) chk("rd_in_hold", 64'(rd_s), 64'd0);
    if (emp_s) chk("rd_when_empty", 64'(rd_s), 64'd0);
    if (prev_hold) chk("hold_stable", 64'(w_s), 64'(prev_w));
    prev_hold = v_s && !r_s && !reset;
    prev_w = w_s;
    if (v_s && r_s && !reset) accept(w_s, be_s);
    @(posedge rd_clk);
    #1;
    edge_n++;
    if (rd_s && !emp_s) begin
      fifo_data = fq.pop_front();
      pops++;
      if (first_pop_edge < 0) first_pop_edge = edge_n;
      last_pop_edge = edge_n;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag, input int max);
    int k = 0;
    while (!word_valid && k < max) begin
      tick();
      k++;
    end
    if (!word_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Packer reset drops every popped byte that never left in an accepted word
  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    while (pops > emitted) begin
      void'(exp_q.pop_front());
      emitted++;
    end
  endtask

  initial begin
    int p0;
    // Reset with data waiting in the FIFO
    push(8'h55); push(8'h66);
    run(1);
    chk("rst_rd", 64'(fifo_rd), 64'd0);
    run(1);
    chk("rst_rd2", 64'(fifo_rd), 64'd0);
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_word", 64'(word_out), 64'd0);
    chk("rst_be", 64'(word_be), 64'd0);
    fq.delete(); exp_q.delete(); fifo_empty = 1'b1;
    reset = 1'b0;
    run(2);

    // Basic pack and first-pop latency
    word_ready = 1'b1;
    first_pop_edge = -1;
    p0 = pops;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid("pack", 20);
    chk("pack_latency", 64'(edge_n - first_pop_edge), 64'(BPW));
    chk("pack_word", 64'(word_out), 64'h44332211);
    chk("pack_be", 64'(word_be), 64'hF);
    run(4);
    chk("pack_pops", 64'(pops - p0), 64'd4);
    chk("pack_fifo_empty", 64'(fq.size()), 64'd0);

    // Backpressure
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    run(15);
    chk("bp_valid", 64'(word_valid), 64'd1);
    chk("bp_word", 64'(word_out), 64'h04030201);
    chk("bp_rd", 64'(fifo_rd), 64'd0);
    chk("bp_fifo_left", 64'(fq.size()), 64'd4);
    word_ready = 1'b1;
    run(1);
    wait_valid("bp2", 20);
    chk("bp_word2", 64'(word_out), 64'h08070605);
    run(3);

    // Stall mid-word
    push(8'hA1); push(8'hA2);
    run(12);
    chk("stall_novalid", 64'(word_valid), 64'd0);
    push(8'hA3); push(8'hA4);
    wait_valid("stall", 20);
    chk("stall_word", 64'(word_out), 64'hA4A3A2A1);
    run(3);

    // Reset mid-word
    push(8'hE1); push(8'hE2);
    run(4);
    do_reset();
    chk("rstmid_valid", 64'(word_valid), 64'd0);
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    wait_valid("rstmid", 20);
    chk("rstmid_word", 64'(word_out), 64'hB4B3B2B1);
    chk("rstmid_be", 64'(word_be), 64'hF);
    run(3);

    // Partial word after idle
    push(8'hC1); push(8'hC2);
`ifdef FIFO_WORD_PACKER_FLUSH_EN
    wait_valid("flush", 40);
    chk("flush_word", 64'(word_out), 64'h0000C2C1);
    chk("flush_be", 64'(word_be), 64'h3);
    chk("flush_delay", 64'(edge_n - (last_pop_edge + 1)), 64'(TO));
    run(3);
`else
    run(40);
    chk("noflush_valid", 64'(word_valid), 64'd0);
    push(8'hC3); push(8'hC4);
    wait_valid("noflush", 20);
    chk("noflush_word", 64'(word_out), 64'hC4C3C2C1);
    run(3);
`endif

    // Randomised traffic against the byte-stream model
    for (int c = 0; c < 400; c++) begin
      if (fq.size() < 8 && $urandom_range(0, 3) != 0) push(8'($urandom));
      word_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    word_ready = 1'b1;
    while (exp_q.size() % BPW != 0) push(8'($urandom));
    run(80);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(word_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
